// File: rtl/draw_engine_pkg.sv
// rtl/draw_engine_pkg.sv - shared dimensions, widths and state encodings for the draw engine
package draw_engine_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 16;
    localparam int SPRITE_H = 16;
    localparam int COLOUR_W = 3;

    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int MAP_AW = 15;
    localparam int SPR_XW = 4;
    localparam int SPR_YW = 4;
    localparam int SPR_AW = 8;

    localparam logic [COLOUR_W-1:0] TRANSPARENT = 3'b101;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_MAP        = 4'd1,
        S_MAP_FLUSH  = 4'd2,
        S_MAP_DONE   = 4'd3,
        S_LINK       = 4'd4,
        S_LINK_FLUSH = 4'd5,
        S_LINK_DONE  = 4'd6,
        S_WAIT       = 4'd7
    } state_e;
endpackage

// File: rtl/draw_scan_counter.sv
// rtl/draw_scan_counter.sv - row-major x/y scan with a running linear address and last-pixel flag
module draw_scan_counter #(
    parameter int W  = 160,
    parameter int H  = 120,
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int AW = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [AW-1:0] addr_q;
    logic          x_end;

    assign x_end  = (x_q == XW'(W - 1));
    assign last_o = x_end && (y_q == YW'(H - 1));
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign addr_o = addr_q;

    // Wrapping to zero on the last pixel leaves the counter ready for the next scan.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else if (en_i) begin
            if (last_o) begin
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end else begin
                addr_q <= addr_q + AW'(1);
                if (x_end) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/draw_engine.sv
// rtl/draw_engine.sv - background and Link sprite renderer driving the VGA adapter plot port
module draw_engine
    import draw_engine_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                draw_map,
    input  logic                draw_link,
    input  logic [X_W-1:0]      link_x,
    input  logic [Y_W-1:0]      link_y,
    output logic [MAP_AW-1:0]   map_rom_addr,
    input  logic [COLOUR_W-1:0] map_rom_data,
    output logic [SPR_AW-1:0]   link_rom_addr,
    input  logic [COLOUR_W-1:0] link_rom_data,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                draw_map_done,
    output logic                draw_link_done,
    output logic                busy
);
    state_e state_q, state_d;
    logic   flush_q;

    logic [X_W-1:0]    map_x;
    logic [Y_W-1:0]    map_y;
    logic              map_last, map_en;
    logic [SPR_XW-1:0] spr_x;
    logic [SPR_YW-1:0] spr_y;
    logic              spr_last, spr_en;

    logic [X_W-1:0] link_x_q;
    logic [Y_W-1:0] link_y_q;
    logic           link_start;

    logic           s1_valid_q, s1_sprite_q;
    logic [X_W:0]   s1_x_q, s1_x_d;
    logic [Y_W:0]   s1_y_q, s1_y_d;

    logic [COLOUR_W-1:0] pix_colour;
    logic                plot_d;
    logic                vga_plot_q;
    logic [X_W-1:0]      vga_x_q;
    logic [Y_W-1:0]      vga_y_q;
    logic [COLOUR_W-1:0] vga_colour_q;

    assign map_en     = (state_q == S_MAP);
    assign spr_en     = (state_q == S_LINK);
    assign link_start = (state_q == S_IDLE) && !draw_map && draw_link;

    draw_scan_counter #(.W(SCREEN_W), .H(SCREEN_H), .XW(X_W), .YW(Y_W), .AW(MAP_AW)) u_map_scan (
        .clk_i(clock), .rst_i(reset), .en_i(map_en),
        .x_o(map_x), .y_o(map_y), .addr_o(map_rom_addr), .last_o(map_last)
    );

    draw_scan_counter #(.W(SPRITE_W), .H(SPRITE_H), .XW(SPR_XW), .YW(SPR_YW), .AW(SPR_AW)) u_spr_scan (
        .clk_i(clock), .rst_i(reset), .en_i(spr_en),
        .x_o(spr_x), .y_o(spr_y), .addr_o(link_rom_addr), .last_o(spr_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (draw_map)       state_d = S_MAP;
                else if (draw_link) state_d = S_LINK;
            end
            S_MAP:        if (map_last) state_d = S_MAP_FLUSH;
            S_MAP_FLUSH:  if (flush_q)  state_d = S_MAP_DONE;
            S_MAP_DONE:   state_d = S_WAIT;
            S_LINK:       if (spr_last) state_d = S_LINK_FLUSH;
            S_LINK_FLUSH: if (flush_q)  state_d = S_LINK_DONE;
            S_LINK_DONE:  state_d = S_WAIT;
            S_WAIT:       if (!draw_map && !draw_link) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Coordinates travel one stage behind the address so they meet the ROM data.
    always_comb begin
        s1_x_d = {1'b0, map_x};
        s1_y_d = {1'b0, map_y};
        if (spr_en) begin
            s1_x_d = {1'b0, link_x_q} + {{(X_W + 1 - SPR_XW){1'b0}}, spr_x};
            s1_y_d = {1'b0, link_y_q} + {{(Y_W + 1 - SPR_YW){1'b0}}, spr_y};
        end
    end

    assign pix_colour = s1_sprite_q ? link_rom_data : map_rom_data;
    assign plot_d     = s1_valid_q && (!s1_sprite_q ||
                        ((pix_colour != TRANSPARENT) &&
                         (s1_x_q < (X_W + 1)'(SCREEN_W)) &&
                         (s1_y_q < (Y_W + 1)'(SCREEN_H))));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            flush_q      <= 1'b0;
            link_x_q     <= '0;
            link_y_q     <= '0;
            s1_valid_q   <= 1'b0;
            s1_sprite_q  <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            vga_plot_q   <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= (state_q == S_MAP_FLUSH) || (state_q == S_LINK_FLUSH);
            if (link_start) begin
                link_x_q <= link_x;
                link_y_q <= link_y;
            end
            s1_valid_q  <= map_en || spr_en;
            s1_sprite_q <= spr_en;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            vga_plot_q  <= plot_d;
            if (plot_d) begin
                vga_x_q      <= s1_x_q[X_W-1:0];
                vga_y_q      <= s1_y_q[Y_W-1:0];
                vga_colour_q <= pix_colour;
            end
        end
    end

    assign vga_plot       = vga_plot_q;
    assign vga_x          = vga_x_q;
    assign vga_y          = vga_y_q;
    assign vga_colour     = vga_colour_q;
    assign draw_map_done  = (state_q == S_MAP_DONE);
    assign draw_link_done = (state_q == S_LINK_DONE);
    assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_draw_engine.sv
// tb/tb_draw_engine.sv - directed checks of map draw, sprite overlay, clipping, arbitration and reset
module tb_draw_engine;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        draw_map = 1'b0;
    logic        draw_link = 1'b0;
    logic [7:0]  link_x = '0;
    logic [6:0]  link_y = '0;
    logic [14:0] map_rom_addr;
    logic [2:0]  map_rom_data = '0;
    logic [7:0]  link_rom_addr;
    logic [2:0]  link_rom_data = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        draw_map_done;
    logic        draw_link_done;
    logic        busy;

    logic sprite_mode = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    int plots, bad, clip_bad, done_edge, first_plot_edge, last_plot_edge, map_dones, link_dones;
    logic [7:0] first_x, last_x;
    logic [6:0] first_y, last_y;
    logic [2:0] first_c, last_c;

    draw_engine dut (
        .clock(clock), .reset(reset), .draw_map(draw_map), .draw_link(draw_link),
        .link_x(link_x), .link_y(link_y),
        .map_rom_addr(map_rom_addr), .map_rom_data(map_rom_data),
        .link_rom_addr(link_rom_addr), .link_rom_data(link_rom_data),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .draw_map_done(draw_map_done), .draw_link_done(draw_link_done), .busy(busy)
    );

    always #5 clock = ~clock;

    // Synchronous ROM models; sprite mode 1 makes every even address transparent.
    always @(posedge clock) begin
        map_rom_data  <= map_rom_addr[2:0];
        link_rom_data <= (sprite_mode && !link_rom_addr[0]) ? 3'b101 : 3'b010;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Edge numbering: edge 1 is the first edge after the request was raised.
    task automatic run_draw(input bit want_link, input bit map_seq, input int start_e, input int budget);
        plots = 0; bad = 0; clip_bad = 0; done_edge = 0;
        first_plot_edge = 0; last_plot_edge = 0; map_dones = 0; link_dones = 0;
        for (int e = start_e + 1; e <= budget && done_edge == 0; e++) begin
            step();
            if (vga_plot) begin
                if (plots == 0) begin
                    first_x = vga_x; first_y = vga_y; first_c = vga_colour; first_plot_edge = e;
                end
                last_x = vga_x; last_y = vga_y; last_c = vga_colour; last_plot_edge = e;
                if (map_seq && (vga_x != 8'(plots % 160) || vga_y != 7'(plots / 160) ||
                                vga_colour != 3'(plots & 7)))
                    bad++;
                if (vga_x > 8'd159 || vga_y > 7'd119 || (!map_seq && vga_colour == 3'b101))
                    clip_bad++;
                plots++;
            end
            if (draw_map_done)  map_dones++;
            if (draw_link_done) link_dones++;
            if (want_link ? draw_link_done : draw_map_done) done_edge = e;
        end
    endtask

    initial begin
        step();
        step();
        check("reset_outputs", {vga_plot, draw_map_done, draw_link_done, busy, vga_x, vga_y, vga_colour}, 0);
        check("reset_addrs", {map_rom_addr, link_rom_addr}, 0);
        reset = 1'b0;
        step();
        check("idle_busy", busy, 0);

        // Full background draw
        draw_map = 1'b1;
        run_draw(1'b0, 1'b1, 0, 19300);
        check("map_plots", plots, 19200);
        check("map_seq_errors", bad, 0);
        check("map_first_edge", first_plot_edge, 3);
        check("map_first_pix", {first_x, first_y, first_c}, {8'd0, 7'd0, 3'd0});
        check("map_last_pix", {last_x, last_y, last_c}, {8'd159, 7'd119, 3'd7});
        check("map_done_edge", done_edge, 19203);
        check("map_done_after_last", last_plot_edge, 19202);
        check("map_done_pulses", {map_dones, link_dones}, {32'd1, 32'd0});
        draw_map = 1'b0;
        step();
        check("map_wait", {draw_map_done, busy, vga_plot}, 3'b010);
        step();
        check("map_idle", busy, 0);

        // Opaque sprite; position and request change after start must be ignored
        link_x = 8'd10; link_y = 7'd20; sprite_mode = 1'b0; draw_link = 1'b1;
        step();
        link_x = 8'd99; link_y = 7'd99; draw_link = 1'b0;
        run_draw(1'b1, 1'b0, 1, 400);
        check("spr_plots", plots, 256);
        check("spr_first_edge", first_plot_edge, 3);
        check("spr_first_pix", {first_x, first_y, first_c}, {8'd10, 7'd20, 3'd2});
        check("spr_last_pix", {last_x, last_y, last_c}, {8'd25, 7'd35, 3'd2});
        check("spr_done_edge", done_edge, 259);
        check("spr_done_pulses", {map_dones, link_dones}, {32'd0, 32'd1});
        step();
        step();
        check("spr_idle", {busy, draw_link_done}, 2'b00);

        // Transparency and clipping at the bottom-right corner
        link_x = 8'd150; link_y = 7'd110; sprite_mode = 1'b1; draw_link = 1'b1;
        run_draw(1'b1, 1'b0, 0, 400);
        check("clip_plots", plots, 50);
        check("clip_bad", clip_bad, 0);
        check("clip_first_pix", {first_x, first_y}, {8'd151, 7'd110});
        check("clip_last_pix", {last_x, last_y}, {8'd159, 7'd119});
        check("clip_done_edge", done_edge, 259);
        draw_link = 1'b0;
        step();
        step();
        check("clip_idle", busy, 0);

        // Both requests at once: map wins, sprite blocked in wait until both drop
        link_x = 8'd10; link_y = 7'd20; sprite_mode = 1'b0;
        draw_map = 1'b1; draw_link = 1'b1;
        run_draw(1'b0, 1'b1, 0, 19300);
        check("both_map_plots", plots, 19200);
        check("both_map_seq", bad, 0);
        check("both_first_pix", {first_x, first_y}, {8'd0, 7'd0});
        check("both_done_edge", done_edge, 19203);
        check("both_no_link_done", link_dones, 0);
        draw_map = 1'b0;
        plots = 0; link_dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (vga_plot) plots++;
            if (draw_link_done) link_dones++;
        end
        check("wait_blocks_plots", {plots, link_dones}, {32'd0, 32'd0});
        check("wait_busy", busy, 1);
        draw_link = 1'b0;
        step();
        check("wait_release", busy, 0);
        plots = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (vga_plot || busy) plots++;
        end
        check("no_retrigger", plots, 0);

        // Asynchronous reset in the middle of a map draw
        draw_map = 1'b1;
        plots = 0;
        for (int e = 1; e <= 6000 && plots < 5001; e++) begin
            step();
            if (vga_plot) plots++;
        end
        check("rst_reached_5000", plots, 5001);
        check("rst_pix_5000", {vga_plot, vga_x, vga_y}, {1'b1, 8'd40, 7'd31});
        #2 reset = 1'b1;
        #1;
        check("rst_async_outputs", {vga_plot, draw_map_done, busy, vga_x, vga_y}, 0);
        check("rst_async_addr", map_rom_addr, 0);
        draw_map = 1'b0;
        plots = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (vga_plot || draw_map_done || draw_link_done) plots++;
        end
        check("rst_no_done", plots, 0);
        reset = 1'b0;
        step();
        draw_map = 1'b1;
        run_draw(1'b0, 1'b1, 0, 5);
        check("restart_first_edge", first_plot_edge, 3);
        check("restart_first_pix", {first_x, first_y, first_c}, {8'd0, 7'd0, 3'd0});
        draw_map = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
